// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-entry holding buffer so queued bytes go out gap-free.
// Optional even parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic             r_stop_idx;
  logic [7:0]       r_buf;
  logic             r_buf_full;
  logic [7:0]       r_shift;
  logic             r_ready;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  logic w_bit_end;
  logic w_last_stop;
  logic w_accept;
  logic w_load;

  assign w_bit_end   = (r_clk_cnt == CNT_LAST);
  assign w_last_stop = (r_stop_idx == STOP_LAST);
  assign w_accept    = tx_valid && r_ready;
  // Buffer drains into the shifter when idle or at the very last stop-bit cycle
  assign w_load      = r_buf_full &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end && w_last_stop));

  // Line outputs are registered from the current state, so they trail the FSM by one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_ready    <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end
      r_ready <= !(w_accept || (r_buf_full && !w_load));

      if (w_load) begin
        r_shift <= r_buf;
      end

      case (r_state)
        S_IDLE: begin
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_clk_cnt  <= '0;
          r_bit_idx  <= '0;
          r_stop_idx <= 1'b0;
          if (w_load) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          r_tx      <= 1'b0;
          r_busy    <= 1'b1;
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
          if (w_bit_end) begin
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          r_tx      <= r_shift[r_bit_idx];
          r_busy    <= 1'b1;
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          r_tx      <= ^r_shift;
          r_busy    <= 1'b1;
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
          if (w_bit_end) begin
            r_state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          r_tx      <= 1'b1;
          r_busy    <= 1'b1;
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_stop_idx <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= w_load ? S_START : S_IDLE;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready = r_ready;
  assign tx       = r_tx;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx; a line monitor decodes frames and pops bytes from a scoreboard.
module tb_uart_tx;

  localparam int CPB  = 2;
  localparam int CPB2 = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS     = 11;
  localparam int DATA_END2 = 10;
`else
  localparam int NBITS     = 10;
  localparam int DATA_END2 = 9;
`endif
  localparam int FRAME_CYC  = NBITS * CPB;
  localparam int FRAME_CYC2 = (NBITS + 1) * CPB2;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       tx2;
  logic       tx_busy2;
  logic       tx_done2;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int frames_done = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic mon_armed = 1'b1;
  logic [7:0] exp_q[$];
  int starts[$];
  int ends[$];

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_busy === 1'b1) busy_cnt++;
    if (tx_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode one frame per start bit; every cycle of the frame is shape-checked
  always begin : monitor
    logic [7:0] rx;
    logic       par;
    logic       shape_ok;
    logic [7:0] exp_b;
    int         b;
    int         start_c;
    @(negedge clk);
    if (mon_armed && reset === 1'b1 && tx === 1'b0) begin
      start_c  = cyc;
      shape_ok = 1'b1;
      rx       = '0;
      par      = 1'b0;
      for (int c = 0; c < FRAME_CYC; c++) begin
        if (c > 0) @(negedge clk);
        b = c / CPB;
        if (tx_busy !== 1'b1) shape_ok = 1'b0;
        if (tx_done !== ((c == FRAME_CYC - 1) ? 1'b1 : 1'b0)) shape_ok = 1'b0;
        if (b == 0) begin
          if (tx !== 1'b0) shape_ok = 1'b0;
        end else if (b <= 8) begin
          if (c % CPB == 0) rx[b-1] = tx;
          else if (tx !== rx[b-1]) shape_ok = 1'b0;
`ifdef UART_TX_PARITY_EN
        end else if (b == 9) begin
          if (c % CPB == 0) par = tx;
          else if (tx !== par) shape_ok = 1'b0;
`endif
        end else begin
          if (tx !== 1'b1) shape_ok = 1'b0;
        end
      end
      starts.push_back(start_c);
      ends.push_back(cyc);
      check("frame_shape", 32'(shape_ok), 32'd1);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        check("frame_byte", 32'(rx), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
        check("parity_bit", 32'(par), 32'(^exp_b));
`endif
      end
      frames_done++;
    end
  end

  // Offer a byte and hold tx_valid until it is accepted; returns just after the accept edge
  task automatic send(input logic [7:0] byte_v);
    int t;
    t = 0;
    @(negedge clk);
    tx_data  = byte_v;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 32'(tx_ready), 32'd1);
    exp_q.push_back(byte_v);
    @(posedge clk);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_done < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("frames_timeout", 32'(frames_done >= n), 32'd1);
  endtask

  initial begin : stim
    int base;
    int b0;
    int d0;
    logic quiet;
    reset     = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    tx_data2  = 8'h00;
    tx_valid2 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_ready2", 32'(tx_ready2), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(tx_ready), 32'd1);
    check("rel_ready2", 32'(tx_ready2), 32'd1);

    // Single frame 0x05 with latency checks
    base = frames_done; b0 = busy_cnt; d0 = done_cnt;
    send(8'h05);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'hC3;
    check("lat_p0_tx", 32'(tx), 32'd1);
    check("lat_p0_busy", 32'(tx_busy), 32'd0);
    check("lat_p0_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("lat_p1_tx", 32'(tx), 32'd1);
    check("lat_p1_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    check("lat_p2_tx", 32'(tx), 32'd0);
    check("lat_p2_busy", 32'(tx_busy), 32'd1);
    wait_frames(base + 1);
    @(negedge clk);
    check("t1_idle_busy", 32'(tx_busy), 32'd0);
    check("t1_busy_cycles", 32'(busy_cnt - b0), 32'(FRAME_CYC));
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Back-to-back 0x05 then 0x02
    base = frames_done; d0 = done_cnt;
    send(8'h05);
    send(8'h02);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h3C;
    wait_frames(base + 2);
    @(negedge clk);
    check("b2b_start_gap", 32'(starts[base+1] - starts[base]), 32'(FRAME_CYC));
    check("b2b_done_gap", 32'(ends[base+1] - ends[base]), 32'(FRAME_CYC));
    check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    // Back-pressure: tx_valid held high across three bytes
    base = frames_done;
    send(8'h01);
    send(8'h03);
    send(8'h04);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_frames(base + 3);
    @(negedge clk);
    check("bp_frames", 32'(frames_done - base), 32'd3);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Parity-relevant bytes
    base = frames_done;
    send(8'h07);
    send(8'h03);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_frames(base + 2);
    @(negedge clk);

    // Reset during data bit 3 of 0xFF, with 0x5A waiting in the buffer
    mon_armed = 1'b0;
    send(8'hFF);
    send(8'h5A);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_tx_bit3", 32'(tx), 32'd1);
    check("mid_busy", 32'(tx_busy), 32'd1);
    check("mid_ready_full", 32'(tx_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_done", 32'(tx_done), 32'd0);
    check("abort_ready", 32'(tx_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("after_ready", 32'(tx_ready), 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    check("after_line_quiet", 32'(quiet), 32'd1);
    exp_q.delete();
    mon_armed = 1'b1;

    // Two stop bits at 4 clocks per bit: send 0x00
    @(negedge clk);
    tx_data2  = 8'h00;
    tx_valid2 = 1'b1;
    check("d2_ready", 32'(tx_ready2), 32'd1);
    @(posedge clk);
    @(negedge clk);
    tx_valid2 = 1'b0;
    tx_data2  = 8'hFF;
    @(negedge clk);
    check("d2_p1_tx", 32'(tx2), 32'd1);
    for (int c = 0; c < FRAME_CYC2; c++) begin
      logic [2:0] exp_v;
      @(negedge clk);
      exp_v = {((c / CPB2) < DATA_END2) ? 1'b0 : 1'b1, 1'b1,
               (c == FRAME_CYC2 - 1) ? 1'b1 : 1'b0};
      check($sformatf("d2_cyc%0d", c), 32'({tx2, tx_busy2, tx_done2}), 32'(exp_v));
    end
    @(negedge clk);
    check("d2_end_busy", 32'(tx_busy2), 32'd0);
    check("d2_end_tx", 32'(tx2), 32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter. It is the transmit counterpart of the CPU's rx receive path and drives the tx pin of the CPU top level.
- Accepts bytes from the peripheral/data-memory side over a valid/ready handshake.
- Serialises each byte as 8N1 (optional parity): LSB first, idle-high line.
- One-entry holding buffer in front of the shift register, so consecutive frames go out back-to-back with no idle gap.

Parameters:
CLKS_PER_BIT, 10417, clock cycles per bit period; legal range >= 2 (the simulation bench uses 2 at a 100 ns clock).
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
tx_data  input  8  byte to transmit; sampled when tx_valid && tx_ready.
tx_valid  input  1  byte-offer strobe from the producer.
tx_ready  output  1  holding buffer is empty and can accept a byte.
tx  output  1  serial line; idle high.
tx_busy  output  1  a frame is being shifted out.
tx_done  output  1  one-cycle pulse marking the end of a frame.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset values (reset low at a clock edge):
  - tx=1, tx_busy=0, tx_done=0, tx_ready=0 while reset is held, tx_ready=1 on the first cycle after release.
  - Holding buffer empty; FSM in IDLE; all counters at 0.
- Reset mid-frame: the frame is aborted, tx returns to 1 at the next edge, and the buffered byte is discarded.
- Registered outputs: every output comes from a flop. tx_ready must not depend combinationally on tx_valid.
- Handshake:
  - A byte is accepted at an edge where tx_valid=1 and tx_ready=1.
  - The byte goes into the holding buffer and tx_ready drops the following cycle.
  - tx_valid while tx_ready=0 is ignored; the producer holds the byte.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - clk_cnt counts 0..CLKS_PER_BIT-1 within each bit period.
  - bit_idx counts 0..7; stop_idx counts 0..STOP_BITS-1.
- IDLE:
  - tx=1, tx_busy=0.
  - If the buffer is full: move it into the shifter, empty the buffer, go to START.
- Latency: a byte accepted at edge N with the FSM idle moves to the shifter at N+1. tx goes low and tx_busy goes high at N+2.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shifter[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to PARITY (macro defined) or STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 only in the final cycle of the last stop bit.
- End of the last stop cycle:
  - Buffer full: load the shifter and go directly to START. The next start bit begins the very next cycle, tx_busy stays 1, and there are zero idle cycles.
  - Buffer empty: go to IDLE; tx_busy drops.
- Simultaneous events: if the shifter loads from the buffer at the same edge a new byte is accepted, the buffer holds the new byte and the shifter holds the old one. tx_ready is 0 the next cycle, and no byte is lost or duplicated.
- tx_data is never sampled outside an accept edge. Changing it mid-frame has no effect.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = even parity = XOR of the 8 data bits, held CLKS_PER_BIT cycles.
  - Frame length is (11 + STOP_BITS - 1) bit periods.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame length is (10 + STOP_BITS - 1) bit periods.

Test Plan:
1. CLKS_PER_BIT=2: send 0x05 -> tx bit sequence 0,1,0,1,0,0,0,0,0,1, each bit 2 cycles; tx_busy high 20 cycles; tx_done pulses once, in cycle 20.
2. Back-to-back: offer 0x05, then 0x02 while the first frame is in flight -> two contiguous 20-cycle frames with no idle cycle. Second data bits are 0,1,0,0,0,0,0,0. tx_done pulses twice, 20 cycles apart.
3. Back-pressure: keep tx_valid high with 0x01, 0x03, 0x04 presented in turn -> each is accepted only when tx_ready=1; the line carries 0x01, 0x03, 0x04 in order with none dropped.
4. Reset mid-frame: pull reset low during DATA bit 3 of 0xFF -> next edge gives tx=1, tx_busy=0, tx_done=0; after release tx stays 1 and tx_ready=1.
5. UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; each frame is 22 cycles.
6. STOP_BITS=2, CLKS_PER_BIT=4: send 0x00 -> tx high for 8 cycles after the data bits; tx_done in the 8th stop cycle; total frame 44 cycles.
